// File: rtl/msg_schedule_pkg.sv
// msg_schedule_pkg: shared widths, FSM states and SHA-256 small-sigma helpers
// for the message schedule expander.
package msg_schedule_pkg;
    localparam int WORD_W  = 32;
    localparam int NUM_IN  = 16;
    localparam int NUM_OUT = 64;

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    function automatic logic [WORD_W-1:0] ror(input logic [WORD_W-1:0] x, input int unsigned n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    function automatic logic [WORD_W-1:0] shr(input logic [WORD_W-1:0] x, input int unsigned n);
        return x >> n;
    endfunction

    function automatic logic [WORD_W-1:0] lsigma0(input logic [WORD_W-1:0] x);
        return ror(x, 7) ^ ror(x, 18) ^ shr(x, 3);
    endfunction

    function automatic logic [WORD_W-1:0] lsigma1(input logic [WORD_W-1:0] x);
        return ror(x, 17) ^ ror(x, 19) ^ shr(x, 10);
    endfunction
endpackage

// File: rtl/msg_schedule_sched_word.sv
// sched_word: one step of the SHA-256 schedule recurrence,
// W[t] = lsigma1(W[t-2]) + W[t-7] + lsigma0(W[t-15]) + W[t-16] mod 2^32.
module sched_word
    import msg_schedule_pkg::*;
(
    input  logic [WORD_W-1:0] w_m2_i,
    input  logic [WORD_W-1:0] w_m7_i,
    input  logic [WORD_W-1:0] w_m15_i,
    input  logic [WORD_W-1:0] w_m16_i,
    output logic [WORD_W-1:0] next_o
);
    assign next_o = lsigma1(w_m2_i) + w_m7_i + lsigma0(w_m15_i) + w_m16_i;
endmodule

// File: rtl/msg_schedule.sv
// msg_schedule: loads 16 message words, then streams W0..W63 from a sliding
// 16-word window whose tail is refilled by the schedule recurrence.
module msg_schedule
    import msg_schedule_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [WORD_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic [5:0]        out_index
);
    state_t            state_q, state_d;
    logic [4:0]        lcnt_q, lcnt_d;
    logic [5:0]        t_q, t_d;
    logic [WORD_W-1:0] w_q [NUM_IN];
    logic [WORD_W-1:0] w_d [NUM_IN];
    logic [WORD_W-1:0] w_new;
    logic              in_acc, out_acc;

    // window slot i holds W[t+i], so the recurrence taps are fixed slots
    sched_word u_sched_word (
        .w_m2_i  (w_q[14]),
        .w_m7_i  (w_q[9]),
        .w_m15_i (w_q[1]),
        .w_m16_i (w_q[0]),
        .next_o  (w_new)
    );

    assign in_ready  = state_q == ST_LOAD;
    assign out_valid = state_q == ST_EMIT;
    assign out_data  = out_valid ? w_q[0] : '0;
    assign out_index = t_q;
    assign out_last  = out_valid && t_q == 6'd63;
    assign in_acc    = in_ready && in_valid;
    assign out_acc   = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        lcnt_d  = lcnt_q;
        t_d     = t_q;
        w_d     = w_q;
        if (clear) begin
            state_d = ST_LOAD;
            lcnt_d  = '0;
            t_d     = '0;
        end else if (in_acc) begin
            w_d[lcnt_q[3:0]] = in_data;
            lcnt_d  = (lcnt_q == 5'd15) ? '0 : lcnt_q + 5'd1;
            state_d = (lcnt_q == 5'd15) ? ST_EMIT : ST_LOAD;
            t_d     = '0;
        end else if (out_acc) begin
            for (int i = 0; i < NUM_IN - 1; i++) w_d[i] = w_q[i+1];
            w_d[NUM_IN-1] = w_new;
            t_d     = t_q + 6'd1;
            state_d = (t_q == 6'd63) ? ST_LOAD : ST_EMIT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_LOAD;
            lcnt_q  <= '0;
            t_q     <= '0;
            w_q     <= '{default: '0};
        end else begin
            state_q <= state_d;
            lcnt_q  <= lcnt_d;
            t_q     <= t_d;
            w_q     <= w_d;
        end
    end
endmodule

// File: tb/tb_msg_schedule.sv
// tb_msg_schedule: randomized self-checking bench for msg_schedule against an
// array-based SHA-256 schedule model.
module tb_msg_schedule;
    logic        clk = 0;
    logic        rst_n = 0;
    logic        clear = 0;
    logic [31:0] in_data = 0;
    logic        in_valid = 0;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 0;
    logic        out_last;
    logic [5:0]  out_index;

    int checks = 0;
    int errors = 0;
    logic [31:0] blk [16];
    logic [31:0] exp_w [64];
    logic [31:0] got [64];

    always #5 clk = ~clk;

    msg_schedule dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .out_index (out_index)
    );

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        logic [63:0] d;
        d = {x, x} >> n;
        return d[31:0];
    endfunction

    task automatic gen_model();
        for (int t = 0; t < 64; t++)
            if (t < 16) exp_w[t] = blk[t];
            else exp_w[t] = (rotr(exp_w[t-2], 17) ^ rotr(exp_w[t-2], 19) ^ (exp_w[t-2] >> 10))
                          + exp_w[t-7]
                          + (rotr(exp_w[t-15], 7) ^ rotr(exp_w[t-15], 18) ^ (exp_w[t-15] >> 3))
                          + exp_w[t-16];
    endtask

    task automatic load_abc();
        for (int i = 0; i < 16; i++) blk[i] = 32'h0;
        blk[0]  = 32'h61626380;
        blk[15] = 32'h00000018;
        gen_model();
    endtask

    task automatic load_random();
        for (int i = 0; i < 16; i++) blk[i] = $urandom;
        gen_model();
    endtask

    // starts and ends at a falling edge; accepts n_words of blk
    task automatic send_block(input int n_words, input int gap_pct);
        int  n = 0;
        int  cyc = 0;
        logic hs;
        while (n < n_words && cyc < 2000) begin
            in_valid = ($urandom_range(99) >= gap_pct);
            in_data  = blk[n];
            hs = in_valid && in_ready;
            @(negedge clk);
            cyc++;
            if (hs) n++;
        end
        in_valid = 0;
        checks++;
        if (n < n_words) begin
            errors++;
            $display("FAIL send_timeout: accepted %0d, required %0d", n, n_words);
        end
        if (n_words == 16) begin
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL load_to_emit: out_valid=%b in_ready=%b, required 1/0", out_valid, in_ready);
            end
        end
    endtask

    // starts and ends at a falling edge; consumes n_words outputs from t=0
    task automatic recv_block(input int n_words, input int stall_pct);
        int k = 0;
        int cyc = 0;
        logic hs;
        logic stalled = 0;
        logic [31:0] pd = 0;
        logic [5:0]  pi = 0;
        while (k < n_words && cyc < 4000) begin
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL emit_flags t=%0d: out_valid=%b in_ready=%b, required 1/0", k, out_valid, in_ready);
            end
            checks++;
            if (out_data !== exp_w[k]) begin
                errors++;
                $display("FAIL out_data t=%0d: got %h, required %h", k, out_data, exp_w[k]);
            end
            checks++;
            if (out_index !== k[5:0]) begin
                errors++;
                $display("FAIL out_index: got %0d, required %0d", out_index, k);
            end
            checks++;
            if (out_last !== (k == 63)) begin
                errors++;
                $display("FAIL out_last t=%0d: got %b, required %b", k, out_last, k == 63);
            end
            if (stalled) begin
                checks++;
                if (out_data !== pd || out_index !== pi) begin
                    errors++;
                    $display("FAIL stall_hold: got %h/%0d, required %h/%0d", out_data, out_index, pd, pi);
                end
            end
            got[k] = out_data;
            pd = out_data;
            pi = out_index;
            out_ready = ($urandom_range(99) >= stall_pct);
            hs = out_ready;
            stalled = !out_ready;
            @(negedge clk);
            cyc++;
            if (hs) k++;
        end
        out_ready = 0;
        checks++;
        if (k < n_words) begin
            errors++;
            $display("FAIL recv_timeout: got %0d words, required %0d", k, n_words);
        end
        if (n_words == 64) begin
            checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL block_done: in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (in_ready !== 1 || out_valid !== 0 || out_last !== 0 || out_index !== 0 || out_data !== 0) begin
            errors++;
            $display("FAIL reset: in_ready=%b out_valid=%b out_last=%b out_index=%0d out_data=%h, required 1/0/0/0/0",
                     in_ready, out_valid, out_last, out_index, out_data);
        end
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic test_abc();
        load_abc();
        send_block(16, 0);
        recv_block(64, 0);
        checks++;
        if (got[16] !== 32'h61626380 || got[17] !== 32'h000F0000) begin
            errors++;
            $display("FAIL abc_w16_w17: got %h %h, required 61626380 000f0000", got[16], got[17]);
        end
    endtask

    task automatic test_random();
        for (int b = 0; b < 3; b++) begin
            load_random();
            send_block(16, 0);
            recv_block(64, 0);
        end
    endtask

    task automatic test_backpressure();
        for (int b = 0; b < 2; b++) begin
            load_random();
            send_block(16, 40);
            recv_block(64, 50);
        end
    endtask

    task automatic test_clear();
        load_random();
        send_block(7, 0);
        clear = 1;
        in_valid = 1;
        in_data = 32'hDEADBEEF;
        @(negedge clk);
        clear = 0;
        in_valid = 0;
        checks++;
        if (in_ready !== 1 || out_valid !== 0) begin
            errors++;
            $display("FAIL clear_load: in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
        end
        load_abc();
        send_block(16, 0);
        recv_block(30, 0);
        clear = 1;
        out_ready = 1;
        @(negedge clk);
        clear = 0;
        out_ready = 0;
        checks++;
        if (out_valid !== 0 || in_ready !== 1 || out_index !== 0) begin
            errors++;
            $display("FAIL clear_emit: out_valid=%b in_ready=%b out_index=%0d, required 0/1/0", out_valid, in_ready, out_index);
        end
        checks++;
        if (got[17] !== 32'h000F0000) begin
            errors++;
            $display("FAIL clear_abc_w17: got %h, required 000f0000", got[17]);
        end
        load_random();
        send_block(16, 0);
        recv_block(64, 0);
    endtask

    task automatic test_async_reset();
        load_random();
        send_block(16, 0);
        recv_block(20, 0);
        #2 rst_n = 0;
        #1;
        checks++;
        if (out_valid !== 0 || in_ready !== 1 || out_data !== 0 || out_index !== 0) begin
            errors++;
            $display("FAIL async_reset: out_valid=%b in_ready=%b out_data=%h out_index=%0d, required 0/1/0/0",
                     out_valid, in_ready, out_data, out_index);
        end
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        load_abc();
        send_block(16, 0);
        recv_block(64, 0);
    endtask

    task automatic test_back_to_back();
        logic [31:0] nxt [16];
        load_random();
        for (int i = 0; i < 16; i++) nxt[i] = $urandom;
        send_block(16, 0);
        in_valid = 1;
        in_data  = nxt[0];
        recv_block(64, 0);
        for (int i = 0; i < 16; i++) blk[i] = nxt[i];
        gen_model();
        send_block(16, 0);
        recv_block(64, 0);
    endtask

    initial begin
        test_reset();
        test_abc();
        test_random();
        test_backpressure();
        test_clear();
        test_async_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/msg_schedule.md
Name: msg_schedule

Overview:
- Sequential SHA-256 message schedule expander.
- Accepts one 512-bit block as 16 big-endian 32-bit words W0..W15 over a valid/ready input stream.
- Emits W0..W63 in order over a valid/ready output stream, one word per handshake, for the compression round logic.
- Computes W16..W63 internally with the existing lsigma0 and lsigma1 blocks.

Parameters:
- NUM_IN, 16, words loaded per block (fixed by SHA-256; not for override).
- NUM_OUT, 64, words emitted per block (fixed by SHA-256; not for override).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous abort; returns the block to LOAD; priority over all handshakes.
- in_data  input  32  message word, W0 first.
- in_valid  input  1  in_data valid.
- in_ready  output  1  block can accept a word.
- out_data  output  32  schedule word W[t].
- out_valid  output  1  out_data valid.
- out_ready  input  1  consumer accepts out_data.
- out_last  output  1  high with out_valid while t=63.
- out_index  output  6  current t (0..63).

Behaviour:
- Storage: 16x32 window w[0..15] plus a 5-bit load count lcnt and a 6-bit emit count t.
- In EMIT, w[i] holds W[t+i].
- States: LOAD, EMIT.
- Reset (rst_n low, async): state=LOAD, lcnt=0, t=0, window cleared to 0. Outputs: in_ready=1, out_valid=0, out_last=0, out_index=0, out_data=0.
- LOAD:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready: w[lcnt] <= in_data; lcnt++.
  - On the 16th accept (lcnt==15): go to EMIT, lcnt=0, t=0.
- EMIT:
  - in_ready=0, out_valid=1, out_data=w[0], out_index=t, out_last=(t==63).
  - All outputs are registered/state-derived; no combinational in->out path.
  - On out_valid&&out_ready: shift w[i] <= w[i+1] for i=0..14, and w[15] <= lsigma1(w[14]) + w[9] + lsigma0(w[1]) + w[0], addition mod 2^32 (carries discarded). Then t++.
  - The uniform recurrence also runs for t>=48; the words it generates past W63 are never emitted and are harmless.
  - Handshake on t==63 returns to LOAD.
- Latency:
  - First accept to first output valid: 16 accept cycles plus 1 (out_valid rises the cycle after the 16th accept).
  - Back-to-back blocks: in_ready rises the cycle after the last output handshake.
  - Throughput is 1 word/cycle in each phase; no overlap of load and emit.
- Backpressure: out_ready low holds out_data, out_index, out_last and the window stable indefinitely.
- in_valid while in_ready=0 is ignored (not an error).
- clear: next state LOAD, lcnt=0, t=0, out_valid=0; window contents are don't-care. Any handshake in that cycle is discarded.
- rst_n asserted mid-LOAD or mid-EMIT: immediate return to reset values; the partial block is lost.
- X-safety: the window is reset so out_data never propagates X after reset.

Decomposition:
- Shared include msg_schedule_defs.vh: SHA256_WORD_W=32, SCHED_IN_WORDS=16, SCHED_OUT_WORDS=64, state encodings ST_LOAD=1'b0, ST_EMIT=1'b1.
- Reuse the existing lsigma0, lsigma1, shr, ror blocks.
- One natural combinational sub-module: sched_word. Inputs are w_m2, w_m7, w_m15, w_m16; output is the next word.
- Top-level msg_schedule holds the FSM, counters and the window.

Test Plan:
- "abc" block: load 0x61626380, fourteen 0x00000000, then 0x00000018 with out_ready=1. Required: outputs W0..W15 equal to the inputs, W16=0x61626380, W17=0x000F0000, 64 words total, out_last only on t=63.
- Random blocks with a software reference model: all 64 words match. Each block takes 16+64 handshakes, then in_ready=1.
- Backpressure: toggle out_ready randomly (50%) and drop in_valid in gaps. Required: no word skipped or duplicated, out_data stable while out_valid&&!out_ready, out_index increments only on handshake.
- clear after 7 loaded words, then a fresh "abc" block: W17=0x000F0000. Issue clear again at t=30; required: out_valid=0 next cycle, in_ready=1, lcnt=0.
- Async reset: pull rst_n low mid-EMIT between clock edges. Required: out_valid=0 and in_ready=1 immediately, out_data=0. After release, the next block is processed correctly.
- Back-to-back blocks with in_valid held high: in_ready=0 during EMIT, and the second block's first word is accepted the cycle after the first block's t=63 handshake.
